idmem_ctrl: RTL and testbench

IDMEM_CTRL -- requirements
Module: idmem_ctrl

---
 rtl/idmem_if.sv | 23 ++
 rtl/idmem_ctrl.sv | 151 +++++++++++++++
 tb/tb_idmem_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/idmem_if.sv
// Request/response bundle between a bus master and idmem_ctrl.
// One request in flight; response is a single-cycle strobe.
interface idmem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [3:0]  req_be;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_be, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_be, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/idmem_ctrl.sv
// Instruction/data scratchpad controller with two independent
// word arrays, byte-enabled writes and fixed read latency.
module idmem_ctrl #(
    parameter logic [31:0] IMEM_BASE  = 32'h0010_0000,
    parameter int          IMEM_WORDS = 1024,
    parameter logic [31:0] DMEM_BASE  = 32'h8000_0000,
    parameter int          DMEM_WORDS = 1024,
    parameter int          READ_LAT   = 1,
    parameter int          IMEM_WR_EN = 1
) (
    input  logic   clk,
    input  logic   rst_n,
    idmem_if.slave bus
);

    localparam int IAW = $clog2(IMEM_WORDS);
    localparam int DAW = $clog2(DMEM_WORDS);
    localparam logic [31:0] IMEM_BYTES = 32'(IMEM_WORDS * 4);
    localparam logic [31:0] DMEM_BYTES = 32'(DMEM_WORDS * 4);
    localparam logic [1:0] CNT_LAST =
        2'((READ_LAT > 1) ? (READ_LAT - 2) : 0);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        isel_q, isel_d;
    logic        dsel_q, dsel_d;

    logic [31:0] ioff, doff;
    logic        in_i, in_d, hit_d;
    logic [IAW-1:0] iidx;
    logic [DAW-1:0] didx;
    logic        accept, err_now;
    logic        imem_we, imem_re, dmem_we, dmem_re;

    logic [31:0] imem_mem [IMEM_WORDS];
    logic [31:0] dmem_mem [DMEM_WORDS];
    logic [31:0] imem_rd_q, dmem_rd_q;

    // Subtraction wraps, so addresses below a base land far out of range.
    assign ioff  = bus.req_addr - IMEM_BASE;
    assign doff  = bus.req_addr - DMEM_BASE;
    assign in_i  = ioff < IMEM_BYTES;
    assign in_d  = doff < DMEM_BYTES;
    assign hit_d = in_d && !in_i;
    assign iidx  = IAW'(ioff >> 2);
    assign didx  = DAW'(doff >> 2);

    assign accept  = bus.req_valid && bus.req_ready;
    assign err_now = (bus.req_addr[1:0] != 2'b00)
                   || !(in_i || in_d)
                   || (bus.req_we && in_i && (IMEM_WR_EN == 0))
                   || (bus.req_we && (bus.req_be == 4'h0));

    assign imem_we = accept && !err_now && bus.req_we && in_i;
    assign imem_re = accept && !err_now && !bus.req_we && in_i;
    assign dmem_we = accept && !err_now && bus.req_we && hit_d;
    assign dmem_re = accept && !err_now && !bus.req_we && hit_d;

    assign bus.req_ready = (state_q == S_IDLE);
    assign bus.rsp_valid = (state_q == S_RESP);
    assign bus.rsp_err   = bus.rsp_valid && err_q;
    assign bus.rsp_rdata = !bus.rsp_valid ? 32'h0 :
                           isel_q ? imem_rd_q :
                           dsel_q ? dmem_rd_q : 32'h0;

    // Instruction array: byte-enabled write, registered read port.
    always_ff @(posedge clk) begin
        if (imem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.req_be[b]) begin
                    imem_mem[iidx][8*b +: 8] <= bus.req_wdata[8*b +: 8];
                end
            end
        end
        if (imem_re) begin
            imem_rd_q <= imem_mem[iidx];
        end
    end

    // Data array: byte-enabled write, registered read port.
    always_ff @(posedge clk) begin
        if (dmem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.req_be[b]) begin
                    dmem_mem[didx][8*b +: 8] <= bus.req_wdata[8*b +: 8];
                end
            end
        end
        if (dmem_re) begin
            dmem_rd_q <= dmem_mem[didx];
        end
    end

    // Transaction FSM: capture status at acceptance, then time the response.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        isel_d  = isel_q;
        dsel_d  = dsel_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    err_d   = err_now;
                    isel_d  = imem_re;
                    dsel_d  = dmem_re;
                    cnt_d   = 2'd0;
                    state_d = (bus.req_we || READ_LAT == 1) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = 2'(cnt_q + 2'd1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                cnt_d   = 2'd0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 2'd0;
            end
        endcase
    end

    // Control state registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
            err_q   <= 1'b0;
            isel_q  <= 1'b0;
            dsel_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            isel_q  <= isel_d;
            dsel_q  <= dsel_d;
        end
    end

endmodule

// File: tb/tb_idmem_ctrl.sv
// Directed bench for idmem_ctrl: three parameterisations sharing
// one clock and reset, selected one at a time for requests.
module tb_idmem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          sel = 0;
    logic        valid = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  be = 4'h0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;

    int checks = 0;
    int failures = 0;

    logic [31:0] rd;
    logic        er;
    int          lat;
    logic        bz;

    always #5 clk = ~clk;

    idmem_if i0 ();
    idmem_if i1 ();
    idmem_if i2 ();

    assign i0.req_valid = valid && (sel == 0);
    assign i0.req_we    = we;
    assign i0.req_be    = be;
    assign i0.req_addr  = addr;
    assign i0.req_wdata = wdata;
    assign i1.req_valid = valid && (sel == 1);
    assign i1.req_we    = we;
    assign i1.req_be    = be;
    assign i1.req_addr  = addr;
    assign i1.req_wdata = wdata;
    assign i2.req_valid = valid && (sel == 2);
    assign i2.req_we    = we;
    assign i2.req_be    = be;
    assign i2.req_addr  = addr;
    assign i2.req_wdata = wdata;

    idmem_ctrl dut0 (.clk(clk), .rst_n(rst_n), .bus(i0));
    idmem_ctrl #(.READ_LAT(3)) dut1 (.clk(clk), .rst_n(rst_n), .bus(i1));
    idmem_ctrl #(.IMEM_WR_EN(0)) dut2 (.clk(clk), .rst_n(rst_n), .bus(i2));

    logic        s_ready, s_valid, s_err;
    logic [31:0] s_rdata;

    assign s_ready = (sel == 0) ? i0.req_ready :
                     (sel == 1) ? i1.req_ready : i2.req_ready;
    assign s_valid = (sel == 0) ? i0.rsp_valid :
                     (sel == 1) ? i1.rsp_valid : i2.rsp_valid;
    assign s_err   = (sel == 0) ? i0.rsp_err :
                     (sel == 1) ? i1.rsp_err : i2.rsp_err;
    assign s_rdata = (sel == 0) ? i0.rsp_rdata :
                     (sel == 1) ? i1.rsp_rdata : i2.rsp_rdata;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One transaction on DUT s; called and returns at a falling edge.
    task automatic xact(input int s, input logic w, input logic [3:0] b,
                        input logic [31:0] a, input logic [31:0] d);
        int n;
        sel = s;
        n = 0;
        while (!s_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("ready_timeout", {31'b0, s_ready}, 32'd1);
        valid = 1'b1;
        we    = w;
        be    = b;
        addr  = a;
        wdata = d;
        @(negedge clk);
        valid = 1'b0;
        we    = ~w;
        be    = ~b;
        addr  = ~a;
        wdata = ~d;
        lat = 1;
        bz  = !s_ready;
        while (!s_valid && lat < 10) begin
            @(negedge clk);
            lat++;
            bz = bz & !s_ready;
        end
        rd = s_rdata;
        er = s_err;
        @(negedge clk);
    endtask

    initial begin
        logic seen;
        dut2.imem_mem[1] = 32'hCAFE_F00D;

        repeat (2) @(negedge clk);
        check("rst_valid", {31'b0, i0.rsp_valid}, 32'd0);
        check("rst_err", {31'b0, i0.rsp_err}, 32'd0);
        check("rst_rdata", i0.rsp_rdata, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", {31'b0, i0.req_ready}, 32'd1);

        xact(0, 1'b1, 4'hF, 32'h0010_0000, 32'h5555_5555);
        check("w1_lat", lat, 1);
        check("w1_err", {31'b0, er}, 32'd0);
        check("w1_rdata", rd, 32'h0);
        xact(0, 1'b0, 4'h0, 32'h0010_0000, 32'h0);
        check("r1_lat", lat, 1);
        check("r1_rdata", rd, 32'h5555_5555);
        check("r1_err", {31'b0, er}, 32'd0);

        xact(0, 1'b1, 4'hF, 32'h8000_000C, 32'hAABB_CCDD);
        xact(0, 1'b1, 4'b0101, 32'h8000_000C, 32'h1122_3344);
        check("be_werr", {31'b0, er}, 32'd0);
        xact(0, 1'b0, 4'h0, 32'h8000_000C, 32'h0);
        check("be_rdata", rd, 32'hAA22_CC44);

        xact(0, 1'b1, 4'hF, 32'h0010_0FFC, 32'h0123_4567);
        check("itop_werr", {31'b0, er}, 32'd0);
        xact(0, 1'b0, 4'h0, 32'h0010_0FFC, 32'h0);
        check("itop_rdata", rd, 32'h0123_4567);
        xact(0, 1'b1, 4'hF, 32'h8000_0FFC, 32'h89AB_CDEF);
        xact(0, 1'b0, 4'h0, 32'h8000_0FFC, 32'h0);
        check("dtop_rdata", rd, 32'h89AB_CDEF);
        check("dtop_err", {31'b0, er}, 32'd0);

        xact(0, 1'b0, 4'h0, 32'h0010_0002, 32'h0);
        check("mis_err", {31'b0, er}, 32'd1);
        check("mis_rdata", rd, 32'h0);
        xact(0, 1'b0, 4'h0, 32'h4000_0000, 32'h0);
        check("unmap_err", {31'b0, er}, 32'd1);
        check("unmap_rdata", rd, 32'h0);
        xact(0, 1'b0, 4'h0, 32'h000F_FFFC, 32'h0);
        check("below_err", {31'b0, er}, 32'd1);
        xact(0, 1'b0, 4'h0, 32'h0010_1000, 32'h0);
        check("iend_err", {31'b0, er}, 32'd1);
        xact(0, 1'b0, 4'h0, 32'h8000_1000, 32'h0);
        check("dend_err", {31'b0, er}, 32'd1);
        xact(0, 1'b1, 4'hF, 32'h0010_0002, 32'hFFFF_FFFF);
        check("mis_werr", {31'b0, er}, 32'd1);
        check("mis_wrdata", rd, 32'h0);
        xact(0, 1'b1, 4'h0, 32'h8000_000C, 32'hFFFF_FFFF);
        check("be0_err", {31'b0, er}, 32'd1);
        xact(0, 1'b0, 4'h0, 32'h0010_0000, 32'h0);
        check("keep_i", rd, 32'h5555_5555);
        xact(0, 1'b0, 4'h0, 32'h8000_000C, 32'h0);
        check("keep_d", rd, 32'hAA22_CC44);

        xact(1, 1'b1, 4'hF, 32'h8000_0000, 32'hDEAD_BEEF);
        check("l3_wlat", lat, 1);
        xact(1, 1'b0, 4'h0, 32'h8000_0000, 32'h0);
        check("l3_lat", lat, 3);
        check("l3_busy", {31'b0, bz}, 32'd1);
        check("l3_rdata", rd, 32'hDEAD_BEEF);
        check("l3_ready_after", {31'b0, s_ready}, 32'd1);
        check("l3_valid_after", {31'b0, s_valid}, 32'd0);

        xact(2, 1'b1, 4'hF, 32'h0010_0004, 32'h1234_5678);
        check("iwp_err", {31'b0, er}, 32'd1);
        xact(2, 1'b0, 4'h0, 32'h0010_0004, 32'h0);
        check("iwp_rdata", rd, 32'hCAFE_F00D);
        check("iwp_rerr", {31'b0, er}, 32'd0);
        xact(2, 1'b1, 4'hF, 32'h8000_0010, 32'h0BAD_CAFE);
        check("iwp_dwerr", {31'b0, er}, 32'd0);
        xact(2, 1'b0, 4'h0, 32'h8000_0010, 32'h0);
        check("iwp_drdata", rd, 32'h0BAD_CAFE);

        sel   = 1;
        valid = 1'b1;
        we    = 1'b0;
        addr  = 32'h8000_0000;
        @(negedge clk);
        valid = 1'b0;
        check("wait_busy", {31'b0, s_ready}, 32'd0);
        rst_n = 1'b0;
        seen  = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen = seen | s_valid;
        end
        check("abort_err", {31'b0, s_err}, 32'd0);
        check("abort_rdata", s_rdata, 32'h0);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            seen = seen | s_valid;
        end
        check("abort_noresp", {31'b0, seen}, 32'd0);
        check("abort_ready", {31'b0, s_ready}, 32'd1);
        xact(1, 1'b0, 4'h0, 32'h8000_0000, 32'h0);
        check("post_lat", lat, 3);
        check("post_rdata", rd, 32'hDEAD_BEEF);
        check("post_err", {31'b0, er}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
